// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Sequential instruction fetch into a 2-entry {pc, instr} buffer that feeds
//   decode.
//
//   The handshake toward decode is valid/ready. An entry is transferred on any
//   rising edge where if_valid=1 and if_ready=1 and no redirect is requested.
//   While if_valid=1 and if_ready=0, if_pc and if_instr hold stable. if_valid
//   never depends combinationally on if_ready.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem_addr       : word index into instruction memory (combinational)
//   imem_instr      : instruction word for imem_addr, same cycle
//   if_valid/ready  : decode handshake for the buffer head
//   if_instr, if_pc : head instruction and its byte PC
//   redirect_valid  : flush the buffer and restart fetch at redirect_pc
//   redirect_pc     : byte target of the redirect (low two bits ignored)
//   fetch_err       : sticky flag, fetch ran past the end of memory
//   fetch_count     : number of instructions handed to decode
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err,
  output logic [31:0] fetch_count
);

  // The head entry of the buffer lives directly in the output registers
  // (if_valid/if_pc/if_instr); the second entry is the tail. The tail is
  // only ever valid when the head is, so occupancy == head_valid + tail_valid.
  logic [31:0] fetch_pc;
  logic        tail_valid;
  logic [31:0] tail_pc;
  logic [31:0] tail_instr;

  logic [31:0] word_idx;
  logic        in_range;
  logic        pop;
  logic        eligible;
  logic        push;

  assign word_idx  = {2'b00, fetch_pc[31:2]};
  assign imem_addr = word_idx;
  assign in_range  = (word_idx < 32'(IMEM_WORDS));

  // A redirect takes priority: it blocks both the pop and the push.
  assign pop      = if_valid & if_ready & ~redirect_valid;
  // Room exists when the tail slot is free, or when the head leaves this cycle.
  assign eligible = ~redirect_valid & ~fetch_err & (~tail_valid | pop);
  assign push     = eligible & in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= 32'h0;
      if_instr    <= 32'h0;
      tail_valid  <= 1'b0;
      tail_pc     <= 32'h0;
      tail_instr  <= 32'h0;
      fetch_err   <= 1'b0;
      fetch_count <= 32'h0;
    end else if (redirect_valid) begin
      if_valid   <= 1'b0;
      tail_valid <= 1'b0;
      fetch_pc   <= {redirect_pc[31:2], 2'b00};
      fetch_err  <= 1'b0;
    end else begin
      if (pop) begin
        fetch_count <= fetch_count + 32'd1;
        if (tail_valid) begin
          // Tail moves to head; the new word (if any) refills the tail.
          if_pc      <= tail_pc;
          if_instr   <= tail_instr;
          tail_valid <= push;
          if (push) begin
            tail_pc    <= fetch_pc;
            tail_instr <= imem_instr;
          end
        end else begin
          // Buffer held only the head; the new word (if any) replaces it.
          if_valid <= push;
          if (push) begin
            if_pc    <= fetch_pc;
            if_instr <= imem_instr;
          end
        end
      end else if (push) begin
        if (!if_valid) begin
          if_valid <= 1'b1;
          if_pc    <= fetch_pc;
          if_instr <= imem_instr;
        end else begin
          tail_valid <= 1'b1;
          tail_pc    <= fetch_pc;
          tail_instr <= imem_instr;
        end
      end

      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
      end else if (eligible && !in_range) begin
        // Out-of-range fetch: stop fetching, fetch_pc stays frozen.
        fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 128, number of valid instruction-memory words.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port imem_addr, output, 32, word index to instruction memory, equal to {2'b00, fetch_pc[31:2]}.
REQ-006 SHALL have port imem_instr, input, 32, instruction word returned combinationally, in the same cycle, for imem_addr.
REQ-007 SHALL have port if_valid, output, 1, head buffer entry valid toward decode.
REQ-008 SHALL have port if_ready, input, 1, decode accepts the head entry.
REQ-009 SHALL have port if_instr, output, 32, instruction at the buffer head.
REQ-010 SHALL have port if_pc, output, 32, byte PC of if_instr.
REQ-011 SHALL have port redirect_valid, input, 1, branch or jump redirect request.
REQ-012 SHALL have port redirect_pc, input, 32, byte target of the redirect.
REQ-013 SHALL have port fetch_err, output, 1, sticky out-of-range fetch flag.
REQ-014 SHALL have port fetch_count, output, 32, count of instructions handed to decode.

Function
REQ-015 SHALL hold fetch_pc as a 32-bit register and a 2-entry FIFO of {pc, instr} pairs, with occupancy count 0..2.
REQ-016 SHALL push {fetch_pc, imem_instr} and advance fetch_pc by 4 in a cycle when all of these hold: no redirect, fetch_err low, and either count<2 or a pop occurs in the same cycle.
REQ-017 SHALL pop the head entry in a cycle with if_valid=1 and if_ready=1, and increment fetch_count by 1 (wraps modulo 2^32).
REQ-018 SHALL drive if_valid = (count != 0), with if_instr and if_pc taken from the head entry and held stable while if_valid=1 and if_ready=0.
REQ-019 SHALL allow a push and a pop in the same cycle, leaving count unchanged, including at count=2.
REQ-020 SHALL NOT push when count=2 and no pop occurs; fetch_pc holds.
REQ-021 SHALL respond to redirect_valid=1 as follows, with priority over push and pop:
- flush the FIFO to count=0;
- load fetch_pc <= {redirect_pc[31:2], 2'b00};
- clear fetch_err;
- perform no pop and do not increment fetch_count.
REQ-022 SHALL drive if_valid=0 in the cycle after a redirect, and present the target instruction with if_valid=1 in the second cycle after the redirect.
REQ-023 SHALL set fetch_err when fetch_pc[31:2] >= IMEM_WORDS at an otherwise-eligible push; the push is suppressed and fetching stops.
REQ-024 SHALL, while fetch_err=1, keep fetch_pc frozen and let already-buffered entries still drain to decode.
REQ-025 SHALL wrap fetch_pc modulo 2^32 on increment; the out-of-range check still applies.
REQ-026 SHALL register all outputs except imem_addr, which is combinational from fetch_pc.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-transfer, immediately reset these values: fetch_pc=RESET_PC, count=0, if_valid=0, if_instr=0, if_pc=0, fetch_err=0, fetch_count=0.
REQ-028 SHALL, on the first rising clk edge after rst_n deasserts, push the instruction at RESET_PC, so that if_valid=1 after that edge.

Verification
REQ-029 Reset release with if_ready=1 held and memory word i = i -> if_valid=1 one cycle after release; one instruction per cycle; if_pc = 0,4,8,...; if_instr = 0,1,2,...; fetch_count increments every cycle.
REQ-030 if_ready=0 for 5 cycles after reset -> count saturates at 2; imem_addr holds 2; if_instr=0 stays stable; on if_ready=1, delivery continues 0,1,2 with none lost or duplicated.
REQ-031 redirect_valid=1 with redirect_pc=32'h40 while count=2 -> next cycle if_valid=0; following cycle if_pc=0x40, if_instr=word 16; fetch_count unchanged by the flush.
REQ-032 Redirect to 32'h1FC (word 127) with IMEM_WORDS=128 -> word 127 delivered, then fetch_err=1, no further pushes; redirect to 0x0 clears fetch_err and resumes fetching.
REQ-033 redirect_pc=32'h43 -> fetch target 0x40; if_pc=0x40.
REQ-034 rst_n pulsed low mid-stream with count=1 -> all outputs reach their reset values without a clock edge; after release, delivery restarts at RESET_PC.
